// File: rtl/arb2_64bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb2_64bit_pkg
// Description : Shared width default, source tags and output-stage states.
// Revision    : 1.0 - initial release
// ============================================================================
package arb2_64bit_pkg;

    localparam int WIDTH_DEFAULT = 64;

    localparam logic SRC_W0 = 1'b0;
    localparam logic SRC_W1 = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage : arb2_64bit_pkg
`default_nettype wire

// File: rtl/mux2_64bit.sv
`default_nettype none
// ============================================================================
// Module      : mux2_64bit
// Description : Plain 2:1 data multiplexer (i_sel=0 -> i_d0, i_sel=1 -> i_d1).
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_64bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule : mux2_64bit
`default_nettype wire

// File: rtl/arb2_64bit.sv
`default_nettype none
// ============================================================================
// Module      : arb2_64bit
// Description : Two-source round-robin arbiter feeding a single registered
//               output stage with valid/ready handshakes on every side.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_64bit
    import arb2_64bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] w0,
    input  logic             w0_valid,
    output logic             w0_ready,
    input  logic [WIDTH-1:0] w1,
    input  logic             w1_valid,
    output logic             w1_ready,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    input  logic             f_ready,
    output logic             s
);

    stage_state_t     r_state;
    stage_state_t     w_state_next;
    logic [WIDTH-1:0] r_f;
    logic             r_s;
    logic             r_last;
    logic             w_grant;
    logic             w_can_load;
    logic             w_load;
    logic [WIDTH-1:0] w_mux_y;

    mux2_64bit #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_d0  (w0),
        .i_d1  (w1),
        .i_sel (w_grant),
        .o_y   (w_mux_y)
    );

    // Next-state and handshake logic; a tie goes to the source not granted last.
    always_comb begin
        w_state_next = r_state;
        w_grant      = SRC_W0;
        w_can_load   = 1'b0;
        w_load       = 1'b0;
        w0_ready     = 1'b0;
        w1_ready     = 1'b0;

        if (w0_valid && w1_valid) begin
            w_grant = ~r_last;
        end else if (w1_valid) begin
            w_grant = SRC_W1;
        end

        w_can_load = !rst && ((r_state == ST_EMPTY) || f_ready);
        w_load     = w_can_load && (w0_valid || w1_valid);
        w0_ready   = w_load && (w_grant == SRC_W0);
        w1_ready   = w_load && (w_grant == SRC_W1);

        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (f_ready && !w_load) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Data, tag and pointer move only on a real load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_f     <= '0;
            r_s     <= SRC_W0;
            r_last  <= SRC_W1;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_f    <= w_mux_y;
                r_s    <= w_grant;
                r_last <= w_grant;
            end
        end
    end

    assign f       = r_f;
    assign s       = r_s;
    assign f_valid = (r_state == ST_FULL);

endmodule : arb2_64bit
`default_nettype wire

// File: tb/tb_arb2_64bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb2_64bit
// Description : Directed self-checking bench for arb2_64bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb2_64bit;

    logic        clk;
    logic        rst;
    logic [63:0] w0;
    logic        w0_valid;
    logic        w0_ready;
    logic [63:0] w1;
    logic        w1_valid;
    logic        w1_ready;
    logic [63:0] f;
    logic        f_valid;
    logic        f_ready;
    logic        s;

    int checks = 0;
    int errors = 0;

    arb2_64bit #(
        .WIDTH (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w0       (w0),
        .w0_valid (w0_valid),
        .w0_ready (w0_ready),
        .w1       (w1),
        .w1_valid (w1_valid),
        .w1_ready (w1_ready),
        .f        (f),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .s        (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] ef, input logic es, input logic ev);
        chk({tag, ".f"}, f, ef);
        chk({tag, ".s"}, {63'd0, s}, {63'd0, es});
        chk({tag, ".f_valid"}, {63'd0, f_valid}, {63'd0, ev});
    endtask

    task automatic chk_rdy(input string tag, input logic e0, input logic e1);
        #1;
        chk({tag, ".w0_ready"}, {63'd0, w0_ready}, {63'd0, e0});
        chk({tag, ".w1_ready"}, {63'd0, w1_ready}, {63'd0, e1});
    endtask

    initial begin
        // Reset held two cycles with both sources valid
        rst = 1'b1; f_ready = 1'b1;
        w0 = 64'h11; w0_valid = 1'b1;
        w1 = 64'h22; w1_valid = 1'b1;
        chk_rdy("rst_rdy", 1'b0, 1'b0);
        tick();
        tick();
        chk_out("rst", 64'h0, 1'b0, 1'b0);
        chk_rdy("rst_rdy2", 1'b0, 1'b0);

        // Single source w1
        rst = 1'b0;
        w0_valid = 1'b0;
        w1 = 64'hA5A5_0000_0000_0001; w1_valid = 1'b1;
        chk_rdy("single_rdy", 1'b0, 1'b1);
        tick();
        chk_out("single", 64'hA5A5_0000_0000_0001, 1'b1, 1'b1);

        // Fresh reset, then alternating ties
        rst = 1'b1; w0_valid = 1'b0; w1_valid = 1'b0;
        tick();
        chk_out("rst2", 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        w0 = 64'h1; w0_valid = 1'b1;
        w1 = 64'h2; w1_valid = 1'b1;
        f_ready = 1'b1;
        chk_rdy("tie0_rdy", 1'b1, 1'b0);
        tick();
        chk_out("tie0", 64'h1, 1'b0, 1'b1);
        chk_rdy("tie1_rdy", 1'b0, 1'b1);
        tick();
        chk_out("tie1", 64'h2, 1'b1, 1'b1);
        tick();
        chk_out("tie2", 64'h1, 1'b0, 1'b1);
        tick();
        chk_out("tie3", 64'h2, 1'b1, 1'b1);

        // Backpressure: load w0, stall three cycles with w1 waiting
        w0 = 64'hDEAD_BEEF; w0_valid = 1'b1; w1_valid = 1'b0;
        tick();
        chk_out("bp_load", 64'hDEAD_BEEF, 1'b0, 1'b1);
        w0_valid = 1'b0;
        w1 = 64'h33; w1_valid = 1'b1;
        f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp_stall_rdy", 1'b0, 1'b0);
            tick();
            chk_out("bp_stall", 64'hDEAD_BEEF, 1'b0, 1'b1);
        end
        f_ready = 1'b1;
        chk_rdy("bp_release_rdy", 1'b0, 1'b1);
        tick();
        chk_out("bp_release", 64'h33, 1'b1, 1'b1);

        // Drain: no valids, stage empties, f and s hold
        w1_valid = 1'b0;
        chk_rdy("drain_rdy", 1'b0, 1'b0);
        tick();
        chk_out("drain", 64'h33, 1'b1, 1'b0);
        tick();
        chk_out("drain_idle", 64'h33, 1'b1, 1'b0);

        // Pointer untouched by idle cycles: last grant was w1, so w0 wins
        w0 = 64'h44; w0_valid = 1'b1;
        w1 = 64'h55; w1_valid = 1'b1;
        chk_rdy("post_drain_rdy", 1'b1, 1'b0);
        tick();
        chk_out("post_drain", 64'h44, 1'b0, 1'b1);

        // Mid-operation reset while stalled (pointer currently favours w1)
        f_ready = 1'b0;
        chk_rdy("mid_stall_rdy", 1'b0, 1'b0);
        tick();
        chk_out("mid_stall", 64'h44, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        w0 = 64'h66; w1 = 64'h77;
        f_ready = 1'b1;
        chk_rdy("after_rst_rdy", 1'b1, 1'b0);
        tick();
        chk_out("after_rst", 64'h66, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_arb2_64bit
`default_nettype wire
